sap1_ring_counter_ir: RTL and testbench
=======================================

Name: sap1_ring_counter_ir

Overview:
Timing generator and instruction register for the SAP-1 control path. Sits directly upstream of the controller-sequencer decode logic and feeds it:
- the one-hot T-state vector t[5:0];
- the opcode a[3:0], from the upper instruction-register nibble.

It consumes the controller's n_l1, n_e1 and n_hlt strobes. It also provides manual single-step clocking and a retired-instruction counter for debug.

Parameters:
T_STATES, 6, number of one-hot timing states per machine cycle
IR_WIDTH, 8, instruction register width (opcode plus operand)
OPC_WIDTH, 4, opcode field width (upper IR bits)
CNT_WIDTH, 8, retired-instruction counter width

Ports:
clk  in  1  system clock; all state changes on rising edge
clr  in  1  asynchronous, active-high reset
w_bus  in  IR_WIDTH  W bus contents, source for IR load
n_l1  in  1  active-low IR load strobe from controller
n_e1  in  1  active-low IR operand enable from controller
n_hlt  in  1  active-low halt from controller
manual  in  1  1 = single-step mode, 0 = free run
step  in  1  single-step request, synchronous level; a rising edge advances one T-state
t  out  T_STATES  one-hot timing state, t[0]=T1 … t[5]=T6
a  out  OPC_WIDTH  opcode, IR[7:4]
operand  out  IR_WIDTH-OPC_WIDTH  IR[3:0]
operand_en  out  1  high when n_e1 low, qualifies operand onto W bus
halted  out  1  sticky halt indicator
instr_count  out  CNT_WIDTH  retired instructions, wraps

Behaviour:
- Reset (clr=1, asynchronous, dominates every other input):
  - t=000001, IR=0 (so a=0000, operand=0);
  - halted=0, instr_count=0, step edge register=0.
- Advance enable: adv = n_hlt & (~manual | step_rise).
  - step_rise = step & ~step_q, where step_q is step registered every cycle.
- Ring counter: on a rising edge with adv=1, t rotates left one position; t[5] wraps to t[0]. With adv=0, t holds.
- The t vector is always exactly one-hot. If an illegal value is ever detected, force t=000001 on the next edge (defensive recovery).
- IR load:
  - When n_l1=0 at a rising edge and adv=1, IR <= w_bus.
  - IR load is gated by adv, so a frozen T3 cannot reload repeatedly.
  - Otherwise IR holds.
- a and operand are direct IR fields, with zero added latency.
- operand_en = ~n_e1, purely combinational.
- Retired-instruction count: instr_count increments by 1 on the edge where t moves from t[5] to t[0] with adv=1. It wraps modulo 2^CNT_WIDTH.
- Halt:
  - When n_hlt=0 at a rising edge, set halted=1. t and IR freeze.
  - The controller asserts n_hlt from the opcode alone. With HLT loaded at the T3 edge, the machine therefore freezes in T4 (t=001000); halted is 1 from the following edge onward.
  - Only clr leaves halt. step and manual are ignored while n_hlt=0.
- Manual mode:
  - Exactly one T-state advance per step rising edge.
  - A held-high step produces a single advance.
  - Switching manual mid-cycle takes effect on the next edge; no T-state is skipped or repeated.
- Simultaneous events:
  - clr beats everything.
  - n_hlt=0 beats step and free run.
  - An IR load on a halting edge does not occur, because adv=0.
- clr mid-cycle returns t to T1 immediately and asynchronously, regardless of the current T-state.

Decomposition:
- Shared package sap1_pkg holds:
  - T_STATES, IR_WIDTH, OPC_WIDTH;
  - the T-state one-hot constants T1..T6;
  - the opcode constants OP_LDA=0000, OP_ADD=0001, OP_SUB=0010, OP_OUT=1110, OP_HLT=1111.
- The controller decoder uses the same package.
- One natural sub-module: sap1_step_edge, which holds the step register and rising-edge detect. The ring counter, IR and counter stay in the top.

Test Plan:
- Reset then free run, n_hlt=1, n_l1=~t[2] looped back, w_bus=8'h1A:
  - t sequences 000001→000010→…→100000→000001;
  - a=0001 and operand=1010 after the T3 edge;
  - instr_count=1 after the sixth edge.
- Halt: w_bus=8'hF0 with n_hlt driven as ~(a==1111):
  - t freezes at 001000;
  - halted=1;
  - instr_count unchanged over 20 further cycles;
  - clr pulse restores t=000001 and halted=0.
- Manual mode: manual=1, step held high 5 cycles then low, then 3 single-cycle pulses:
  - t advances exactly 4 positions total, reaching 010000;
  - no advance on cycles without a step rising edge.
- Asynchronous clr asserted mid-cycle in T5 (t=010000):
  - t=000001, IR=0, instr_count=0 before the next clk edge.
- Wrap: 256 instructions free run:
  - instr_count returns to 0;
  - t stays one-hot every cycle (assertion).
- operand_en: n_e1 toggled 0/1 with IR=8'h37:
  - operand_en follows ~n_e1 combinationally;
  - operand=0111 stays constant.

Source files
------------

// File: rtl/sap1_pkg.sv
// Shared SAP-1 control-path definitions: widths, T-state encodings, opcodes.
package sap1_pkg;

  localparam int unsigned T_STATES  = 6;
  localparam int unsigned IR_WIDTH  = 8;
  localparam int unsigned OPC_WIDTH = 4;
  localparam int unsigned OPR_WIDTH = IR_WIDTH - OPC_WIDTH;
  localparam int unsigned CNT_WIDTH = 8;

  // One-hot T-state encodings, T1 first.
  localparam logic [T_STATES-1:0] T1 = 6'b000001;
  localparam logic [T_STATES-1:0] T2 = 6'b000010;
  localparam logic [T_STATES-1:0] T3 = 6'b000100;
  localparam logic [T_STATES-1:0] T4 = 6'b001000;
  localparam logic [T_STATES-1:0] T5 = 6'b010000;
  localparam logic [T_STATES-1:0] T6 = 6'b100000;

  localparam logic [OPC_WIDTH-1:0] OP_LDA = 4'b0000;
  localparam logic [OPC_WIDTH-1:0] OP_ADD = 4'b0001;
  localparam logic [OPC_WIDTH-1:0] OP_SUB = 4'b0010;
  localparam logic [OPC_WIDTH-1:0] OP_OUT = 4'b1110;
  localparam logic [OPC_WIDTH-1:0] OP_HLT = 4'b1111;

  // Instruction register layout: opcode in the upper nibble, operand below.
  typedef struct packed {
    logic [OPC_WIDTH-1:0] opc;
    logic [OPR_WIDTH-1:0] opr;
  } ir_t;

  // True when exactly one bit of the T vector is set.
  function automatic logic t_is_onehot(input logic [T_STATES-1:0] t);
    return (t != '0) && ((t & (t - T_STATES'(1))) == '0);
  endfunction

  // Next T-state: rotate left, T6 wraps to T1.
  function automatic logic [T_STATES-1:0] t_rotl(input logic [T_STATES-1:0] t);
    return {t[T_STATES-2:0], t[T_STATES-1]};
  endfunction

endpackage

// File: rtl/sap1_ring_counter_ir_if.sv
// Bus between the controller-sequencer and the timing generator / IR block.
interface sap1_ring_counter_ir_if;
  import sap1_pkg::*;

  logic [IR_WIDTH-1:0]  w_bus;
  logic                 n_l1;
  logic                 n_e1;
  logic                 n_hlt;
  logic                 manual;
  logic                 step;
  logic [T_STATES-1:0]  t;
  logic [OPC_WIDTH-1:0] a;
  logic [OPR_WIDTH-1:0] operand;
  logic                 operand_en;
  logic                 halted;
  logic [CNT_WIDTH-1:0] instr_count;

  // Controller side: drives strobes and W bus, consumes timing and opcode.
  modport master (
    output w_bus, n_l1, n_e1, n_hlt, manual, step,
    input  t, a, operand, operand_en, halted, instr_count
  );

  // Timing generator side.
  modport slave (
    input  w_bus, n_l1, n_e1, n_hlt, manual, step,
    output t, a, operand, operand_en, halted, instr_count
  );

endinterface

// File: rtl/sap1_step_edge.sv
// Single-step request register and rising-edge detector.
module sap1_step_edge (
  input  logic clk,
  input  logic clr,
  input  logic step,
  output logic step_rise_c
);

  logic step_q;

  // Register step every cycle so a held-high level yields one rise.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) step_q <= 1'b0;
    else     step_q <= step;
  end

  assign step_rise_c = step & ~step_q;

endmodule

// File: rtl/sap1_ring_counter_ir.sv
// SAP-1 ring counter, instruction register, halt latch and retired count.
module sap1_ring_counter_ir
  import sap1_pkg::*;
(
  input  logic                   clk,
  input  logic                   clr,
  sap1_ring_counter_ir_if.slave  bus
);

  logic [T_STATES-1:0]  t_q,      t_nxt;
  ir_t                  ir_q,     ir_nxt;
  logic [CNT_WIDTH-1:0] cnt_q,    cnt_nxt;
  logic                 halted_q, halted_nxt;
  logic                 step_rise_c;
  logic                 adv_c;

  sap1_step_edge u_step_edge (
    .clk         (clk),
    .clr         (clr),
    .step        (bus.step),
    .step_rise_c (step_rise_c)
  );

  // Halt overrides both free run and single-step.
  assign adv_c = bus.n_hlt & (~bus.manual | step_rise_c);

  // State registers; clr returns to T1 immediately.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      t_q      <= T1;
      ir_q     <= '0;
      cnt_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      t_q      <= t_nxt;
      ir_q     <= ir_nxt;
      cnt_q    <= cnt_nxt;
      halted_q <= halted_nxt;
    end
  end

  // Next-state: rotate on advance, recover from a corrupted T vector,
  // load IR only on an advancing edge so a frozen T3 cannot reload.
  always_comb begin
    t_nxt      = t_q;
    ir_nxt     = ir_q;
    cnt_nxt    = cnt_q;
    halted_nxt = halted_q;

    if (!t_is_onehot(t_q)) begin
      t_nxt = T1;
    end else if (adv_c) begin
      t_nxt = t_rotl(t_q);
      if (t_q == T6) cnt_nxt = cnt_q + CNT_WIDTH'(1);
    end

    if (adv_c && !bus.n_l1) ir_nxt = ir_t'(bus.w_bus);
    if (!bus.n_hlt)         halted_nxt = 1'b1;
  end

  assign bus.t           = t_q;
  assign bus.a           = ir_q.opc;
  assign bus.operand     = ir_q.opr;
  assign bus.operand_en  = ~bus.n_e1;
  assign bus.halted      = halted_q;
  assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_sap1_ring_counter_ir.sv
// Self-checking bench for sap1_ring_counter_ir against a T-index reference model.
module tb_sap1_ring_counter_ir;
  import sap1_pkg::*;

  logic clk = 1'b0;
  logic clr = 1'b0;

  sap1_ring_counter_ir_if bus ();

  sap1_ring_counter_ir dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: T-state as an index 0..5, IR as a byte, plain counters.
  int         m_ti;
  logic [7:0] m_ir;
  logic       m_halted;
  int         m_cnt;
  logic       m_step_q;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ti = 0; m_ir = 8'h00; m_halted = 1'b0; m_cnt = 0; m_step_q = 1'b0;
  endtask

  task automatic model_edge();
    logic adv;
    adv = bus.n_hlt && (!bus.manual || (bus.step && !m_step_q));
    if (!bus.n_hlt) m_halted = 1'b1;
    if (adv) begin
      if (!bus.n_l1) m_ir = bus.w_bus;
      if (m_ti == T_STATES - 1) m_cnt = (m_cnt + 1) % (1 << CNT_WIDTH);
      m_ti = (m_ti + 1) % T_STATES;
    end
    m_step_q = bus.step;
  endtask

  task automatic compare_all();
    chk("t",           32'(bus.t),           32'(1 << m_ti));
    chk("t_onehot",    32'($onehot(bus.t)),  32'd1);
    chk("a",           32'(bus.a),           32'(m_ir[7:4]));
    chk("operand",     32'(bus.operand),     32'(m_ir[3:0]));
    chk("operand_en",  32'(bus.operand_en),  32'(!bus.n_e1));
    chk("halted",      32'(bus.halted),      32'(m_halted));
    chk("instr_count", 32'(bus.instr_count), 32'(m_cnt));
  endtask

  // One clock: model follows the edge, outputs compared 1 time unit later,
  // then return at the falling edge ready for new inputs.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1 compare_all();
    @(negedge clk);
  endtask

  // Controller loopback: load IR in T3, halt when the opcode is HLT.
  task automatic drive_ctrl();
    bus.n_l1  = !(m_ti == 2);
    bus.n_hlt = !(m_ir[7:4] == OP_HLT);
  endtask

  task automatic clr_pulse();
    clr = 1'b1;
    #1;
    model_reset();
    compare_all();
    #1 clr = 1'b0;
  endtask

  logic [7:0] w;
  int         sched [14] = '{1, 1, 1, 1, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0};

  initial begin
    bus.w_bus = 8'h00; bus.n_l1 = 1'b1; bus.n_e1 = 1'b1; bus.n_hlt = 1'b1;
    bus.manual = 1'b0; bus.step = 1'b0;
    model_reset();

    // Reset state.
    #2 clr = 1'b1;
    #1;
    chk("rst_t",      32'(bus.t),           32'(T1));
    chk("rst_a",      32'(bus.a),           32'd0);
    chk("rst_opr",    32'(bus.operand),     32'd0);
    chk("rst_halted", 32'(bus.halted),      32'd0);
    chk("rst_count",  32'(bus.instr_count), 32'd0);
    @(negedge clk);
    clr = 1'b0;

    // Free run one instruction, ADD 0xA.
    bus.w_bus = 8'h1A;
    for (int i = 0; i < 6; i++) begin
      drive_ctrl();
      cycle();
      if (i == 2) begin
        chk("run_a_after_t3",   32'(bus.a),       32'h1);
        chk("run_opr_after_t3", 32'(bus.operand), 32'hA);
      end
    end
    chk("run_t_wrap", 32'(bus.t),           32'(T1));
    chk("run_count",  32'(bus.instr_count), 32'd1);

    // Halt: HLT loaded at T3 freezes the machine in T4.
    bus.w_bus = 8'hF0;
    for (int i = 0; i < 26; i++) begin
      drive_ctrl();
      cycle();
    end
    chk("hlt_t",      32'(bus.t),           32'(T4));
    chk("hlt_halted", 32'(bus.halted),      32'd1);
    chk("hlt_count",  32'(bus.instr_count), 32'd1);
    clr_pulse();
    chk("hlt_clr_t",      32'(bus.t),      32'(T1));
    chk("hlt_clr_halted", 32'(bus.halted), 32'd0);

    // Manual: held step then three pulses give four advances.
    bus.manual = 1'b1;
    bus.w_bus  = 8'h25;
    foreach (sched[i]) begin
      drive_ctrl();
      bus.step = sched[i][0];
      cycle();
    end
    chk("man_t", 32'(bus.t), 32'(T5));
    chk("man_a", 32'(bus.a), 32'h2);

    // Asynchronous clr in the middle of T5.
    @(posedge clk);
    #2 clr = 1'b1;
    #1;
    chk("aclr_t",     32'(bus.t),           32'(T1));
    chk("aclr_a",     32'(bus.a),           32'd0);
    chk("aclr_opr",   32'(bus.operand),     32'd0);
    chk("aclr_count", 32'(bus.instr_count), 32'd0);
    model_reset();
    @(negedge clk);
    clr = 1'b0;

    // Wrap: 256 instructions of random non-HLT code in free run.
    bus.manual = 1'b0;
    for (int i = 0; i < 256 * T_STATES; i++) begin
      w = 8'($urandom);
      if (w[7:4] == OP_HLT) w[7:4] = OP_OUT;
      bus.w_bus = w;
      bus.n_e1  = 1'($urandom);
      drive_ctrl();
      cycle();
    end
    chk("wrap_count", 32'(bus.instr_count), 32'd0);
    chk("wrap_t",     32'(bus.t),           32'(T1));

    // operand_en follows n_e1 with no clock edge; operand stays put.
    bus.w_bus = 8'h37;
    for (int i = 0; i < 3; i++) begin
      drive_ctrl();
      cycle();
    end
    bus.manual = 1'b1;
    bus.step   = 1'b0;
    bus.n_l1   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.n_e1 = i[0];
      #1;
      chk("oe_follow",  32'(bus.operand_en), 32'(!i[0]));
      chk("oe_operand", 32'(bus.operand),    32'h7);
    end
    cycle();

    // Random mix of all controls with occasional halts and clears.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 79) == 0) clr_pulse();
      bus.manual = 1'($urandom);
      bus.step   = 1'($urandom);
      bus.n_l1   = 1'($urandom);
      bus.n_e1   = 1'($urandom);
      bus.w_bus  = 8'($urandom);
      bus.n_hlt  = ($urandom_range(0, 99) != 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
